// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 instruction decode unit: opcodes, instruction
// classes, ALU operation codes and the decoded bundle layout.
package jedro_1_defines;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned AluOpWidth   = 4;
  localparam int unsigned ClassWidth   = 4;

  localparam logic [6:0] OpcodeLoad    = 7'b0000011;
  localparam logic [6:0] OpcodeMiscMem = 7'b0001111;
  localparam logic [6:0] OpcodeOpImm   = 7'b0010011;
  localparam logic [6:0] OpcodeAuipc   = 7'b0010111;
  localparam logic [6:0] OpcodeStore   = 7'b0100011;
  localparam logic [6:0] OpcodeOp      = 7'b0110011;
  localparam logic [6:0] OpcodeLui     = 7'b0110111;
  localparam logic [6:0] OpcodeBranch  = 7'b1100011;
  localparam logic [6:0] OpcodeJalr    = 7'b1100111;
  localparam logic [6:0] OpcodeJal     = 7'b1101111;
  localparam logic [6:0] OpcodeSystem  = 7'b1110011;

  typedef enum logic [ClassWidth-1:0] {
    ClassAlu    = 4'd0,
    ClassLoad   = 4'd1,
    ClassStore  = 4'd2,
    ClassBranch = 4'd3,
    ClassJal    = 4'd4,
    ClassJalr   = 4'd5,
    ClassLui    = 4'd6,
    ClassAuipc  = 4'd7,
    ClassFence  = 4'd8,
    ClassSystem = 4'd9
  } instr_class_e;

  // {instr[30], funct3} encoding of the RV32I ALU operations
  localparam logic [AluOpWidth-1:0] AluAdd  = 4'b0000;
  localparam logic [AluOpWidth-1:0] AluSub  = 4'b1000;
  localparam logic [AluOpWidth-1:0] AluSll  = 4'b0001;
  localparam logic [AluOpWidth-1:0] AluSlt  = 4'b0010;
  localparam logic [AluOpWidth-1:0] AluSltu = 4'b0011;
  localparam logic [AluOpWidth-1:0] AluXor  = 4'b0100;
  localparam logic [AluOpWidth-1:0] AluSrl  = 4'b0101;
  localparam logic [AluOpWidth-1:0] AluSra  = 4'b1101;
  localparam logic [AluOpWidth-1:0] AluOr   = 4'b0110;
  localparam logic [AluOpWidth-1:0] AluAnd  = 4'b0111;

  typedef struct packed {
    instr_class_e            instr_class;
    logic [AluOpWidth-1:0]   alu_op;
    logic                    reg_op_a;
    logic                    reg_op_b;
    logic [RegAddrWidth-1:0] rs1;
    logic [RegAddrWidth-1:0] rs2;
    logic [RegAddrWidth-1:0] rd;
    logic                    rd_we;
    logic [DataWidth-1:0]    imm;
    logic                    illegal;
  } dec_bundle_t;

  typedef struct packed {
    dec_bundle_t          dec;
    logic [DataWidth-1:0] pc;
  } idu_entry_t;

endpackage

// File: rtl/jedro_1_idu_decode.sv
// Combinational RV32I decoder: raw instruction in, decoded bundle out.
// Illegal encodings collapse to a SYSTEM-class bundle with no writeback.
module jedro_1_idu_decode
  import jedro_1_defines::*;
(
  input  logic [DataWidth-1:0] instr_i,
  output dec_bundle_t          dec_o
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [DataWidth-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_bundle_t          dec;
  logic                 illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                  1'b0};

  always_comb begin
    dec          = '0;
    dec.rs1      = instr_i[19:15];
    dec.rs2      = instr_i[24:20];
    dec.rd       = instr_i[11:7];
    dec.reg_op_a = 1'b1;
    dec.alu_op   = AluAdd;
    illegal      = (instr_i[1:0] != 2'b11);

    case (opcode)
      OpcodeOp: begin
        dec.instr_class = ClassAlu;
        dec.alu_op      = {instr_i[30], funct3};
        dec.reg_op_b    = 1'b1;
        dec.rd_we       = 1'b1;
        if (funct7 == 7'h20) begin
          if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
        end else if (funct7 != 7'h00) begin
          illegal = 1'b1;
        end
      end
      OpcodeOpImm: begin
        dec.instr_class = ClassAlu;
        dec.alu_op      = {(funct3 == 3'b101) & instr_i[30], funct3};
        dec.imm         = imm_i;
        dec.rd_we       = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'h00) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
      end
      OpcodeLoad: begin
        dec.instr_class = ClassLoad;
        dec.imm         = imm_i;
        dec.rd_we       = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end
      OpcodeStore: begin
        dec.instr_class = ClassStore;
        dec.imm         = imm_s;
        if (funct3 > 3'b010) illegal = 1'b1;
      end
      OpcodeBranch: begin
        dec.instr_class = ClassBranch;
        dec.imm         = imm_b;
        dec.reg_op_b    = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OpcodeJal: begin
        dec.instr_class = ClassJal;
        dec.imm         = imm_j;
        dec.reg_op_a    = 1'b0;
        dec.rd_we       = 1'b1;
      end
      OpcodeJalr: begin
        dec.instr_class = ClassJalr;
        dec.imm         = imm_i;
        dec.rd_we       = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OpcodeLui: begin
        dec.instr_class = ClassLui;
        dec.imm         = imm_u;
        dec.reg_op_a    = 1'b0;
        dec.rd_we       = 1'b1;
      end
      OpcodeAuipc: begin
        dec.instr_class = ClassAuipc;
        dec.imm         = imm_u;
        dec.reg_op_a    = 1'b0;
        dec.rd_we       = 1'b1;
      end
      OpcodeMiscMem: begin
        dec.instr_class = ClassFence;
        dec.imm         = imm_i;
      end
      OpcodeSystem: begin
        dec.instr_class = ClassSystem;
        dec.imm         = imm_i;
      end
      default: illegal = 1'b1;
    endcase

    if (dec.rd == '0) dec.rd_we = 1'b0;

    if (illegal) begin
      dec             = '0;
      dec.instr_class = ClassSystem;
      dec.illegal     = 1'b1;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/jedro_1_idu.sv
// Instruction decode unit: registers the decoded bundle behind a valid/ready handshake.
// Define JEDRO_1_IDU_SKID_EN for a one-entry skid buffer with a registered instr_ready_o.
module jedro_1_idu
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALU_OP_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [DATA_WIDTH-1:0]     instr_rdata_i,
  input  logic [DATA_WIDTH-1:0]     instr_addr_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [3:0]                instr_class_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
  output logic                      alu_reg_op_a_o,
  output logic                      alu_reg_op_b_o,
  output logic [REG_ADDR_WIDTH-1:0] alu_reg_op_a_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] alu_reg_op_b_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [DATA_WIDTH-1:0]     instr_addr_o,
  output logic                      illegal_instr_o
);

  dec_bundle_t dec;
  idu_entry_t  in_entry;
  idu_entry_t  out_q, out_d;
  logic        out_valid;
  logic        ready;
  logic        accept;

  jedro_1_idu_decode u_decode (
    .instr_i (instr_rdata_i),
    .dec_o   (dec)
  );

  assign in_entry = '{dec: dec, pc: instr_addr_i};
  assign accept   = instr_valid_i & ready;

`ifdef JEDRO_1_IDU_SKID_EN
  typedef enum logic [1:0] {StEmpty, StFull, StSkid} skid_state_e;

  skid_state_e state_q, state_d;
  idu_entry_t  skid_q, skid_d;
  logic        ready_q, ready_d;

  assign ready     = ready_q;
  assign out_valid = (state_q != StEmpty);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          out_d   = in_entry;
          state_d = StFull;
        end
      end
      StFull: begin
        if (dec_ready_i) begin
          if (accept) out_d = in_entry;
          else        state_d = StEmpty;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (dec_ready_i) begin
          out_d   = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush_i) state_d = StEmpty;
    ready_d = (state_d != StSkid);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end
`else
  logic valid_q, valid_d;

  assign ready     = !valid_q | dec_ready_i;
  assign out_valid = valid_q;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (accept) begin
      out_d   = in_entry;
      valid_d = 1'b1;
    end else if (dec_ready_i) begin
      valid_d = 1'b0;
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end
`endif

  assign instr_ready_o       = ready;
  assign dec_valid_o         = out_valid;
  assign instr_class_o       = out_q.dec.instr_class;
  assign alu_op_sel_o        = out_q.dec.alu_op;
  assign alu_reg_op_a_o      = out_q.dec.reg_op_a;
  assign alu_reg_op_b_o      = out_q.dec.reg_op_b;
  assign alu_reg_op_a_addr_o = out_q.dec.rs1;
  assign alu_reg_op_b_addr_o = out_q.dec.rs2;
  assign rd_addr_o           = out_q.dec.rd;
  assign rd_we_o             = out_q.dec.rd_we;
  assign imm_o               = out_q.dec.imm;
  assign instr_addr_o        = out_q.pc;
  assign illegal_instr_o     = out_q.dec.illegal;

endmodule

// File: tb/tb_jedro_1_idu.sv
// Self-checking bench for jedro_1_idu: directed steps then random traffic, all outputs
// compared against a queue-based reference model of the decode/handshake rules.
module tb_jedro_1_idu;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_rdata_i = '0;
  logic [31:0] instr_addr_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [3:0]  instr_class_o;
  logic [3:0]  alu_op_sel_o;
  logic        alu_reg_op_a_o, alu_reg_op_b_o;
  logic [4:0]  alu_reg_op_a_addr_o, alu_reg_op_b_addr_o, rd_addr_o;
  logic        rd_we_o;
  logic [31:0] imm_o, instr_addr_o;
  logic        illegal_instr_o;

  always #5 clk = ~clk;

  jedro_1_idu dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .instr_valid_i       (instr_valid_i),
    .instr_ready_o       (instr_ready_o),
    .instr_rdata_i       (instr_rdata_i),
    .instr_addr_i        (instr_addr_i),
    .dec_valid_o         (dec_valid_o),
    .dec_ready_i         (dec_ready_i),
    .instr_class_o       (instr_class_o),
    .alu_op_sel_o        (alu_op_sel_o),
    .alu_reg_op_a_o      (alu_reg_op_a_o),
    .alu_reg_op_b_o      (alu_reg_op_b_o),
    .alu_reg_op_a_addr_o (alu_reg_op_a_addr_o),
    .alu_reg_op_b_addr_o (alu_reg_op_b_addr_o),
    .rd_addr_o           (rd_addr_o),
    .rd_we_o             (rd_we_o),
    .imm_o               (imm_o),
    .instr_addr_o        (instr_addr_o),
    .illegal_instr_o     (illegal_instr_o)
  );

  typedef struct packed {
    logic        bad;
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic        ra, rb;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] imm;
  } ref_t;

  typedef struct packed {
    ref_t        r;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   checks_on = 1'b0;

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F,
                           7'h73};

  // Classes numbered in the order ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM
  function automatic ref_t ref_dec(input logic [31:0] i);
    ref_t       r;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [31:0] imm_i = 32'($signed(i) >>> 20);
    r     = '0;
    r.rs1 = i[19:15];
    r.rs2 = i[24:20];
    r.rd  = i[11:7];
    r.ra  = 1'b1;
    r.bad = (i[1:0] != 2'b11);
    if (op == 7'h33) begin
      r.cls = 0; r.alu = {i[30], f3}; r.rb = 1; r.we = 1;
      r.bad |= !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
    end else if (op == 7'h13) begin
      r.cls = 0; r.alu = {(f3 == 5) ? i[30] : 1'b0, f3}; r.imm = imm_i; r.we = 1;
      r.bad |= (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
    end else if (op == 7'h03) begin
      r.cls = 1; r.imm = imm_i; r.we = 1; r.bad |= (f3 == 3 || f3 >= 6);
    end else if (op == 7'h23) begin
      r.cls = 2; r.imm = {{20{i[31]}}, i[31:25], i[11:7]}; r.bad |= (f3 > 2);
    end else if (op == 7'h63) begin
      r.cls = 3; r.rb = 1; r.bad |= (f3 == 2 || f3 == 3);
      r.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    end else if (op == 7'h6F) begin
      r.cls = 4; r.ra = 0; r.we = 1;
      r.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    end else if (op == 7'h67) begin
      r.cls = 5; r.imm = imm_i; r.we = 1; r.bad |= (f3 != 0);
    end else if (op == 7'h37 || op == 7'h17) begin
      r.cls = (op == 7'h37) ? 4'd6 : 4'd7; r.ra = 0; r.we = 1; r.imm = i & 32'hFFFF_F000;
    end else if (op == 7'h0F) begin
      r.cls = 8; r.imm = imm_i;
    end else if (op == 7'h73) begin
      r.cls = 9; r.imm = imm_i;
    end else begin
      r.bad = 1;
    end
    r.we = r.we && (r.rd != 0) && !r.bad;
    if (r.bad) r.cls = 9;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k = $urandom_range(0, 11);
    logic [31:0] w = $urandom;
    if (k == 11) return w;
    w[6:0] = ops[k];
    if (k < 2) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
    end
    if (k == 6 && $urandom_range(0, 1) == 0) w[14:12] = 3'b000;
    return w;
  endfunction

  function automatic logic exp_ready();
`ifdef JEDRO_1_IDU_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || dec_ready_i;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("dec_valid", 32'(dec_valid_o), 32'(q.size() != 0));
    chk("instr_ready", 32'(instr_ready_o), 32'(exp_ready()));
    if (q.size() != 0) begin
      e = q[0];
      chk("illegal", 32'(illegal_instr_o), 32'(e.r.bad));
      chk("rd_we", 32'(rd_we_o), 32'(e.r.we));
      chk("class", 32'(instr_class_o), 32'(e.r.cls));
      if (!e.r.bad) begin
        chk("alu_op", 32'(alu_op_sel_o), 32'(e.r.alu));
        chk("reg_a", 32'(alu_reg_op_a_o), 32'(e.r.ra));
        chk("reg_b", 32'(alu_reg_op_b_o), 32'(e.r.rb));
        chk("rs1", 32'(alu_reg_op_a_addr_o), 32'(e.r.rs1));
        chk("rs2", 32'(alu_reg_op_b_addr_o), 32'(e.r.rs2));
        chk("rd", 32'(rd_addr_o), 32'(e.r.rd));
        chk("imm", imm_o, e.r.imm);
        chk("pc", instr_addr_o, e.pc);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(dec_valid_o), 0);
    chk({tag, "_illegal"}, 32'(illegal_instr_o), 0);
    chk({tag, "_rd_we"}, 32'(rd_we_o), 0);
    chk({tag, "_class"}, 32'(instr_class_o), 0);
    chk({tag, "_alu_op"}, 32'(alu_op_sel_o), 0);
    chk({tag, "_regs"}, {alu_reg_op_a_o, alu_reg_op_b_o, alu_reg_op_a_addr_o,
                         alu_reg_op_b_addr_o, rd_addr_o}, 0);
    chk({tag, "_imm"}, imm_o, 0);
    chk({tag, "_pc"}, instr_addr_o, 0);
    chk({tag, "_ready"}, 32'(instr_ready_o), 1);
  endtask

  // One clock: drive at negedge, compare before the edge, advance the model at the edge.
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic dr, output logic acc);
    @(negedge clk);
    rst_i = r; flush_i = f; instr_valid_i = v; instr_rdata_i = ins; instr_addr_i = pc;
    dec_ready_i = dr;
    #1;
    acc = v && exp_ready();
    if (checks_on) check_outputs();
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      if (q.size() != 0 && dr) q.delete(0);
      if (acc) q.push_back('{r: ref_dec(ins), pc: pc});
    end
  endtask

  initial begin
    logic        acc;
    logic [31:0] trio [3];
    int          idx;
    int          cyc;

    step(1, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, acc);
    checks_on = 1'b1;
    #2 check_zero("reset");

    step(0, 0, 1, 32'h002081B3, 32'h100, 1, acc);
    #2;
    chk("add_valid", 32'(dec_valid_o), 1);
    chk("add_class", 32'(instr_class_o), 0);
    chk("add_alu", 32'(alu_op_sel_o), 0);
    chk("add_addr", {alu_reg_op_a_addr_o, alu_reg_op_b_addr_o, rd_addr_o}, {5'd1, 5'd2, 5'd3});
    chk("add_we", 32'(rd_we_o), 1);
    step(0, 0, 1, 32'h407302B3, 32'h104, 1, acc);
    #2 chk("sub_alu", 32'(alu_op_sel_o), 32'h8);
    step(0, 0, 1, 32'hFFF00093, 32'h108, 1, acc);
    #2;
    chk("addi_imm", imm_o, 32'hFFFF_FFFF);
    chk("addi_reg_b", 32'(alu_reg_op_b_o), 0);
    step(0, 0, 1, 32'h00000000, 32'h10C, 1, acc);
    #2;
    chk("zero_illegal", {dec_valid_o, illegal_instr_o, rd_we_o, instr_class_o}, {3'b110, 4'd9});
    step(0, 0, 1, 32'h0000707F, 32'h110, 1, acc);
    #2;
    chk("ones_illegal", {dec_valid_o, illegal_instr_o, rd_we_o, instr_class_o}, {3'b110, 4'd9});
    step(0, 0, 0, 0, 0, 1, acc);

    // Three back-to-back instructions against a 3-cycle consumer stall
    trio[0] = 32'h002081B3; trio[1] = 32'h407302B3; trio[2] = 32'hFFF00093;
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 20) begin
      step(0, 0, 1, trio[idx], 32'h200 + 32'(idx * 4), (cyc >= 3), acc);
      if (acc) idx++;
      cyc++;
    end
    chk("trio_accepted", 32'(idx), 3);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 1, acc);

    // Flush with a held bundle and a new instruction offered
    step(0, 0, 1, 32'h002081B3, 32'h300, 0, acc);
    step(0, 1, 1, 32'h407302B3, 32'h304, 0, acc);
    #2 chk("flush_valid", 32'(dec_valid_o), 0);
    step(0, 0, 0, 0, 0, 1, acc);

    // Reset in the middle of a stall
    step(0, 0, 1, 32'h002081B3, 32'h400, 0, acc);
    step(0, 0, 1, 32'h407302B3, 32'h404, 0, acc);
    step(1, 0, 1, 32'hFFF00093, 32'h408, 0, acc);
    #2 check_zero("midrst");
    step(0, 0, 0, 0, 0, 1, acc);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), rand_instr(), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 9) < 6), acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
